// File: rtl/adc_ltc2308_scan.sv
// Round-robin scan controller for the LTC2308 8-channel 12-bit SPI ADC.
// Each frame issues a CONVST pulse, waits out the conversion, then runs one 12-bit SPI exchange.
module adc_ltc2308_scan #(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int FRAME_CYCLES  = 200,
  parameter int NUM_CH        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        smp_valid,
  output logic [2:0]  smp_ch,
  output logic [11:0] smp_data
);

  localparam int FW      = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int CNT_A   = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
  localparam int CNT_MAX = (CNT_A > CLK_DIV) ? CNT_A : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_HI,
    S_CONV_WAIT,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e        state_q,    state_d;
  logic [FW-1:0] frame_q,    frame_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [3:0]    bit_q,      bit_d;
  logic [2:0]    ch_q,       ch_d;
  logic [2:0]    prev_ch_q,  prev_ch_d;
  logic          discard_q,  discard_d;
  logic [11:0]   shreg_q,    shreg_d;
  logic [5:0]    cfg_sr_q,   cfg_sr_d;
  logic          convst_q,   convst_d;
  logic          sck_q,      sck_d;
  logic          valid_q,    valid_d;
  logic [2:0]    smp_ch_q,   smp_ch_d;
  logic [11:0]   smp_data_q, smp_data_d;
  logic [2:0]    ch_next;

  // Config word layout: {S/D, O/S, S1, S0, UNI, SLP}, single-ended unipolar, awake.
  function automatic logic [5:0] cfg_word(input logic [2:0] n);
    return {1'b1, n[0], n[2], n[1], 1'b1, 1'b0};
  endfunction

  assign ch_next = (ch_q == 3'(NUM_CH - 1)) ? 3'd0 : ch_q + 3'd1;

  // NOTE: every variable gets its default before the case statement so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ch_d       = ch_q;
    prev_ch_d  = prev_ch_q;
    discard_d  = discard_q;
    shreg_d    = shreg_q;
    cfg_sr_d   = cfg_sr_q;
    sck_d      = sck_q;
    valid_d    = 1'b0;
    smp_ch_d   = smp_ch_q;
    smp_data_d = smp_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_CONV_HI;
          frame_d   = '0;
          cnt_d     = '0;
          discard_d = 1'b1;
          ch_d      = 3'd0;
        end
      end
      S_CONV_HI: begin
        frame_d = frame_q + FW'(1);
        if (cnt_q == CW'(CONVST_CYCLES - 1)) begin
          state_d = S_CONV_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CONV_WAIT: begin
        frame_d = frame_q + FW'(1);
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d  = S_SHIFT;
          cnt_d    = '0;
          bit_d    = 4'd0;
          sck_d    = 1'b0;
          cfg_sr_d = cfg_word(ch_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        frame_d = frame_q + FW'(1);
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            shreg_d = {shreg_q[10:0], adc_sdo};
          end else begin
            // Falling SCK: next config bit (zeros once the 6-bit word is out).
            sck_d    = 1'b0;
            cfg_sr_d = {cfg_sr_q[4:0], 1'b0};
            if (bit_q == 4'd11) begin
              state_d = S_GAP;
              if (!discard_q) begin
                valid_d    = 1'b1;
                smp_data_d = shreg_q;
                smp_ch_d   = prev_ch_q;
              end
              discard_d = 1'b0;
              prev_ch_d = ch_q;
              ch_d      = ch_next;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (frame_q == FW'(FRAME_CYCLES - 1)) begin
          if (en) begin
            state_d = S_CONV_HI;
            frame_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    convst_d = (state_d == S_CONV_HI);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      ch_q       <= '0;
      prev_ch_q  <= '0;
      discard_q  <= 1'b1;
      shreg_q    <= '0;
      cfg_sr_q   <= '0;
      convst_q   <= 1'b0;
      sck_q      <= 1'b0;
      valid_q    <= 1'b0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ch_q       <= ch_d;
      prev_ch_q  <= prev_ch_d;
      discard_q  <= discard_d;
      shreg_q    <= shreg_d;
      cfg_sr_q   <= cfg_sr_d;
      convst_q   <= convst_d;
      sck_q      <= sck_d;
      valid_q    <= valid_d;
      smp_ch_q   <= smp_ch_d;
      smp_data_q <= smp_data_d;
    end
  end

  assign adc_convst = convst_q;
  assign adc_sck    = sck_q;
  assign adc_sdi    = cfg_sr_q[5];
  assign smp_valid  = valid_q;
  assign smp_ch     = smp_ch_q;
  assign smp_data   = smp_data_q;

endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// Bench for adc_ltc2308_scan: a behavioural LTC2308 model logs every conversion and config word,
// and directed steps compare the delivered samples against those logs and fixed frame timing.
module tb_adc_ltc2308_scan;

  localparam int CLK_DIV       = 2;
  localparam int CONVST_CYCLES = 2;
  localparam int CONV_CYCLES   = 80;
  localparam int FRAME_CYCLES  = 200;
  localparam int NUM_CH        = 4;
  // smp_valid appears at this frame-relative cycle; enabling from IDLE costs one extra cycle.
  localparam int VALID_OFS = CONVST_CYCLES + CONV_CYCLES + 24 * CLK_DIV;
  localparam int FIRST_LAT = 1 + FRAME_CYCLES + VALID_OFS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;

  adc_ltc2308_scan #(
    .CLK_DIV      (CLK_DIV),
    .CONVST_CYCLES(CONVST_CYCLES),
    .CONV_CYCLES  (CONV_CYCLES),
    .FRAME_CYCLES (FRAME_CYCLES),
    .NUM_CH       (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .adc_convst(adc_convst),
    .adc_sck   (adc_sck),
    .adc_sdi   (adc_sdi),
    .adc_sdo   (adc_sdo),
    .smp_valid (smp_valid),
    .smp_ch    (smp_ch),
    .smp_data  (smp_data)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- LTC2308 behavioural model ----------------
  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] val;
  } conv_t;

  conv_t       conv_log[$];
  logic [5:0]  cfg_log[$];
  int          sck_per_log[$];
  int          mode = 0;          // 0: 0xABC, 1: 0x100+ch, 2: random, 3: 0xFFF/0x000 alternating
  logic [5:0]  cfg_pend = '0;
  logic [5:0]  cfg_sh = '0;
  bit          alt = 1'b0;
  logic [11:0] conv_val = '0;
  logic [2:0]  conv_ch = '0;
  logic [3:0]  sdo_idx = '0;
  int          sdi_cnt = 0, sck_rises = 0, last_rises = 0;
  int          convst_rise_cyc = 0, convst_width = 0, last_rise_cyc = 0;
  logic        convst_prev = 1'b0, sck_prev = 1'b0;

  always @(adc_convst or adc_sck) begin
    if (adc_convst === 1'b1 && convst_prev === 1'b0) begin
      // Conversion uses the config latched during the previous SPI exchange.
      conv_ch = {cfg_pend[3], cfg_pend[2], cfg_pend[4]};
      case (mode)
        0:       conv_val = 12'hABC;
        1:       conv_val = 12'h100 + 12'(conv_ch);
        3: begin
          conv_val = alt ? 12'h000 : 12'hFFF;
          alt      = ~alt;
        end
        default: conv_val = 12'($urandom);
      endcase
      conv_log.push_back('{ch: conv_ch, val: conv_val});
      last_rises      = sck_rises;
      sck_rises       = 0;
      sdi_cnt         = 0;
      convst_rise_cyc = cyc;
    end
    if (adc_convst === 1'b0 && convst_prev === 1'b1) begin
      convst_width = cyc - convst_rise_cyc;
      sdo_idx      = 4'd11;
      adc_sdo      = conv_val[11];
    end
    if (adc_sck === 1'b1 && sck_prev === 1'b0) begin
      sck_rises = sck_rises + 1;
      if (sck_rises > 1) sck_per_log.push_back(cyc - last_rise_cyc);
      last_rise_cyc = cyc;
      if (sdi_cnt < 6) begin
        cfg_sh  = {cfg_sh[4:0], adc_sdi};
        sdi_cnt = sdi_cnt + 1;
        if (sdi_cnt == 6) begin
          cfg_pend = cfg_sh;
          cfg_log.push_back(cfg_sh);
        end
      end
    end
    if (adc_sck === 1'b0 && sck_prev === 1'b1) begin
      if (sdo_idx > 4'd0) begin
        sdo_idx = sdo_idx - 4'd1;
        adc_sdo = conv_val[sdo_idx];
      end else begin
        adc_sdo = 1'b0;
      end
    end
    convst_prev = adc_convst;
    sck_prev    = adc_sck;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_err = 0;
  int rd    = 0;   // index in conv_log of the conversion the next sample must carry

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for smp_valid; returns its cycle and checks it is one clk wide.
  task automatic take(input string tag, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int i = 0; i < 2 * FRAME_CYCLES + 50 && !got; i++) begin
      @(negedge clk);
      if (smp_valid === 1'b1) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      @(negedge clk);
      check({tag, "_width"}, 32'(smp_valid), 32'd0);
    end
  endtask

  // k-th sample since enable carries channel k mod NUM_CH and the matching conversion result.
  task automatic check_sample(input string tag, input int k);
    int exp_ch;
    exp_ch = k % NUM_CH;
    check({tag, "_ch"}, 32'(smp_ch), 32'(exp_ch));
    if (rd < conv_log.size()) begin
      check({tag, "_cfgch"}, 32'(conv_log[rd].ch), 32'(exp_ch));
      check({tag, "_data"}, 32'(smp_data), 32'(conv_log[rd].val));
    end else begin
      check({tag, "_logged"}, 32'(conv_log.size()), 32'(rd + 1));
    end
    rd++;
  endtask

  task automatic wait_sck_high(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYCLES && !got; i++) begin
      @(negedge clk);
      if (adc_sck === 1'b1) got = 1'b1;
    end
    check({tag, "_sck_seen"}, 32'(got), 32'd1);
  endtask

  logic [5:0] cfg_tbl [4];

  initial begin
    int t, t_prev, t_en, base_cfg, nconv, hi_cnt, mn, mx;
    logic [11:0] prev, want;
    cfg_tbl[0] = 6'b100010;
    cfg_tbl[1] = 6'b110010;
    cfg_tbl[2] = 6'b100110;
    cfg_tbl[3] = 6'b110110;

    // Reset state
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_convst", 32'(adc_convst), 32'd0);
    check("rst_sck",    32'(adc_sck),    32'd0);
    check("rst_sdi",    32'(adc_sdi),    32'd0);
    check("rst_valid",  32'(smp_valid),  32'd0);
    check("rst_ch",     32'(smp_ch),     32'd0);
    check("rst_data",   32'(smp_data),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First sample after enable: first frame discarded, constant 0xABC
    mode     = 0;
    rd       = conv_log.size() + 1;
    base_cfg = cfg_log.size();
    en       = 1'b1;
    t_en     = cyc;
    take("first", t);
    check("first_lat", 32'(t - t_en), 32'(FIRST_LAT));
    check_sample("first", 0);
    check("first_abc", 32'(smp_data), 32'h0ABC);

    // Continuous scan: 0x100+ch, fixed frame spacing
    mode = 1;
    for (int k = 1; k <= 5; k++) begin
      t_prev = t;
      take("scan", t);
      check("scan_spacing", 32'(t - t_prev), 32'(FRAME_CYCLES));
      check_sample("scan", k);
      check("scan_val", 32'(smp_data), 32'h100 + 32'(k % NUM_CH));
    end

    // SPI waveform: config words, CONVST width, SCK period and edge count
    if (cfg_log.size() >= base_cfg + 6) begin
      for (int j = 0; j < 6; j++)
        check("cfg_word", 32'(cfg_log[base_cfg + j]), 32'(cfg_tbl[j % 4]));
    end else begin
      check("cfg_count", 32'(cfg_log.size()), 32'(base_cfg + 6));
    end
    mn = 1000;
    mx = 0;
    foreach (sck_per_log[i]) begin
      if (sck_per_log[i] < mn) mn = sck_per_log[i];
      if (sck_per_log[i] > mx) mx = sck_per_log[i];
    end
    check("sck_per_min", 32'(mn), 32'(2 * CLK_DIV));
    check("sck_per_max", 32'(mx), 32'(2 * CLK_DIV));
    check("convst_width", 32'(convst_width), 32'(CONVST_CYCLES));
    check("sck_rises", 32'(last_rises), 32'd12);

    // en dropped during SHIFT: current frame still delivers, then silence
    wait_sck_high("drop");
    en = 1'b0;
    take("drop", t);
    check_sample("drop", 6);
    nconv  = conv_log.size();
    hi_cnt = 0;
    repeat (3 * FRAME_CYCLES) begin
      @(negedge clk);
      if (adc_convst === 1'b1 || smp_valid === 1'b1) hi_cnt++;
    end
    check("drop_quiet", 32'(hi_cnt), 32'd0);
    check("drop_noconv", 32'(conv_log.size()), 32'(nconv));

    // Re-enable with random data: first frame discarded, channels restart at 0
    mode = 2;
    rd   = conv_log.size() + 1;
    en   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      take("reen", t);
      check_sample("reen", k);
    end

    // Asynchronous reset in the middle of SHIFT
    wait_sck_high("rst");
    #3 rst_n = 1'b0;
    #1;
    check("arst_sck",    32'(adc_sck),    32'd0);
    check("arst_convst", 32'(adc_convst), 32'd0);
    check("arst_valid",  32'(smp_valid),  32'd0);
    check("arst_data",   32'(smp_data),   32'd0);
    check("arst_ch",     32'(smp_ch),     32'd0);
    @(negedge clk);
    mode  = 0;
    rd    = conv_log.size() + 1;
    rst_n = 1'b1;
    t_en  = cyc;
    take("rst1", t);
    check("rst1_lat", 32'(t - t_en), 32'(FIRST_LAT));
    check_sample("rst1", 0);
    check("rst1_abc", 32'(smp_data), 32'h0ABC);

    // Full-scale / zero alternation: no bit slip, data held between pulses
    mode = 3;
    prev = smp_data;
    for (int k = 1; k <= 4; k++) begin
      take("alt", t);
      check_sample("alt", k);
      check("alt_extreme", 32'(smp_data == 12'hFFF || smp_data == 12'h000), 32'd1);
      if (k > 1) begin
        want = ~prev;
        check("alt_flip", 32'(smp_data), 32'(want));
      end
      prev = smp_data;
      repeat (50) @(negedge clk);
      check("alt_hold", 32'(smp_data), 32'(prev));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
